lcd_vote_buffer: RTL and testbench
==================================

Name: lcd_vote_buffer

Overview:
- Source side of the LCD character-memory interface: the LCD driver presents a 5-bit `mem_addr` ({row, col[3:0]}) and this block returns the ASCII byte on `mem_bus`.
- The 2x16 screen shows four candidate tallies (A–D) as decimal text.
- On request, the block snapshots the vote counters and converts each one to BCD by sequential shift-add-3 (double-dabble).
- Each candidate's digits are committed atomically, so the LCD never shows a half-converted number.
- Sits between the vote-counting logic and the LCD driver.

Parameters:
- CNT_W, 10, width of each vote count; legal range 4..13 (max 8191 fits in 4 digits).

Ports:
- clk  input  1  system clock; everything on posedge.
- rst_n  input  1  asynchronous active-low reset.
- cnt_a  input  CNT_W  candidate A tally (binary).
- cnt_b  input  CNT_W  candidate B tally.
- cnt_c  input  CNT_W  candidate C tally.
- cnt_d  input  CNT_W  candidate D tally.
- update_req  input  1  one-cycle pulse requesting a refresh.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when all four candidates have been committed.
- mem_addr  input  5  LCD read address {row, col}.
- mem_bus  output  8  ASCII character at mem_addr; combinational read.

Behaviour:
- Screen layout per row, cols 0..15: `L`, `:`, d3 d2 d1 d0, space, `L`, `:`, d3 d2 d1 d0, space×3.
  - Row 0: letters A, B. Row 1: letters C, D.
  - Digits are stored as 16 nibbles (4 cand × 4). Read returns 0x30 + nibble.
  - Static characters come from address decode, not storage.
- Reset: all digit nibbles = 0 (screen shows "0000"), busy = 0, done = 0, pending = 0, FSM = IDLE.
- Reset mid-conversion aborts the conversion; no partial commit survives.
- FSM states: IDLE -> LOAD -> CONV -> COMMIT -> (LOAD for next candidate | DONE) -> IDLE.
- IDLE:
  - update_req = 1 -> LOAD, candidate index = 0.
  - busy rises in the cycle after the request edge.
- LOAD (1 cycle):
  - Snapshot the selected count into the shift register. Snapshots are taken per candidate at its own LOAD.
  - Clear the 16-bit BCD accumulator.
- CONV (CNT_W cycles):
  - Each cycle: add 3 to any BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - A bit counter tracks the cycles; after CNT_W shifts -> COMMIT.
- COMMIT (1 cycle):
  - Write all 4 nibbles of the current candidate into display storage in one cycle.
  - Increment the candidate index; index 3 -> DONE.
- DONE (1 cycle):
  - done = 1, busy = 0 -> IDLE.
  - If pending = 1: clear pending and go to LOAD instead of IDLE, with busy staying low only during this DONE cycle.
- Latency from the update_req edge to the done pulse: 4·(CNT_W+2)+1 cycles. This is 49 cycles for CNT_W=10.
- update_req while busy: sets pending (a single-deep queue, not a counter). The queued re-run starts on the cycle after done.
- update_req in the DONE cycle: also sets pending.
- Maximum count (2^CNT_W − 1) converts exactly; for CNT_W=10, 1023 displays "1023".
- mem_bus is valid for any mem_addr at any time, including during CONV. Uncommitted candidates keep their previous digits.

Optional Feature:
- Macro: LCD_LEAD_ZERO_BLANK_EN.
- Defined:
  - Leading zeros of each field (d3..d1, left to right, up to the first nonzero digit) read as 0x20 (space).
  - d0 is always shown.
  - Blanking is a read-side decode only; storage is unchanged.
- Undefined: all four digits are always shown as ASCII '0'–'9'.

Decomposition:
- Package lcd_vote_pkg:
  - FSM state enum.
  - ASCII constants (0x30 zero, 0x20 space, 0x3A colon, 0x41..0x44 letters).
  - Column index constants for field starts (2, 9).
- Sub-module bin2bcd_seq: owns the LOAD/CONV shifter and bit counter.
  - Ports: start, bin_in, busy, valid, bcd_out.
  - The parent FSM sequences the candidates and performs COMMIT.

Test Plan:
- Reset, no update; read all 32 addresses -> row 0 "A:0000 B:0000   ", row 1 "C:0000 D:0000   ".
- cnt_a=1023, cnt_b=0, cnt_c=57, cnt_d=400, pulse update_req -> done exactly 49 cycles later; rows read "A:1023 B:0000   " / "C:0057 D:0400   ".
- Hold cnt_c=57 and sample addr {1,2..5} every cycle during conversion -> reads stay at old digits until C's COMMIT cycle, then switch to "0057" in one cycle with no intermediate value.
- Second update_req 10 cycles into the run, with cnt_b changed to 5 mid-run -> one extra run starts after the first done; second done follows 49 cycles later; B shows "0005".
- Assert rst_n low during candidate B's CONV -> busy=0 and all digits "0000" immediately (asynchronous); a fresh update after release completes normally.
- With LCD_LEAD_ZERO_BLANK_EN defined, cnt_c=57 and cnt_b=0 -> C field reads "A:  57"-style spacing as "C:  57" and B field reads "B:   0".

Source files
------------

// File: rtl/lcd_vote_pkg.sv
// Shared types and constants for the LCD vote-tally buffer: FSM states,
// ASCII codes, field column positions and the BCD add-3 correction.
package lcd_vote_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CONV,
    ST_COMMIT,
    ST_DONE
  } state_e;

  localparam int BCD_W = 16;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_A     = 8'h41;
  localparam logic [7:0] ASCII_B     = 8'h42;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_D     = 8'h44;

  localparam logic [3:0] COL_LETTER0 = 4'd0;
  localparam logic [3:0] COL_COLON0  = 4'd1;
  localparam logic [3:0] COL_FIELD0  = 4'd2;
  localparam logic [3:0] COL_LETTER1 = 4'd7;
  localparam logic [3:0] COL_COLON1  = 4'd8;
  localparam logic [3:0] COL_FIELD1  = 4'd9;

  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble): one add-3/shift step
// per cycle after a start pulse; valid pulses once the result is complete.
module bin2bcd_seq
  import lcd_vote_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] bin_in,
  output logic             busy,
  output logic             valid,
  output logic [BCD_W-1:0] bcd_out
);

  localparam int CW = $clog2(CNT_W);

  logic [CNT_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             valid_q, valid_d;

  always_comb begin
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    valid_d  = 1'b0;
    if (start) begin
      bin_d    = bin_in;
      bcd_d    = '0;
      cnt_d    = CW'(CNT_W - 1);
      active_d = 1'b1;
    end else if (active_q) begin
      {bcd_d, bin_d} = {bcd_add3(bcd_q), bin_q} << 1;
      if (cnt_q == '0) begin
        active_d = 1'b0;
        valid_d  = 1'b1;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      valid_q  <= valid_d;
    end
  end

  // busy drops during the final shift so the parent can leave CONV on time
  assign busy    = active_q && (cnt_q != '0);
  assign valid   = valid_q;
  assign bcd_out = bcd_q;

endmodule

// File: rtl/lcd_vote_buffer.sv
// LCD character source for four vote tallies; converts counts to BCD on
// request and commits each candidate atomically. LCD_LEAD_ZERO_BLANK_EN blanks leading zeros.
module lcd_vote_buffer
  import lcd_vote_pkg::*;
#(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cnt_a,
  input  logic [CNT_W-1:0] cnt_b,
  input  logic [CNT_W-1:0] cnt_c,
  input  logic [CNT_W-1:0] cnt_d,
  input  logic             update_req,
  output logic             busy,
  output logic             done,
  input  logic [4:0]       mem_addr,
  output logic [7:0]       mem_bus
);

  state_e           state_q, state_d;
  logic [1:0]       cand_q, cand_d;
  logic             pending_q, pending_d;
  logic [BCD_W-1:0] disp_q [4];

  logic             cv_start, cv_busy, cv_valid, commit_en;
  logic [CNT_W-1:0] cv_bin;
  logic [BCD_W-1:0] cv_bcd;

  always_comb begin
    case (cand_q)
      2'd0:    cv_bin = cnt_a;
      2'd1:    cv_bin = cnt_b;
      2'd2:    cv_bin = cnt_c;
      default: cv_bin = cnt_d;
    endcase
  end

  bin2bcd_seq #(.CNT_W(CNT_W)) u_conv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (cv_start),
    .bin_in  (cv_bin),
    .busy    (cv_busy),
    .valid   (cv_valid),
    .bcd_out (cv_bcd)
  );

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    pending_d = pending_q;
    cv_start  = 1'b0;
    commit_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (update_req) begin
          state_d = ST_LOAD;
          cand_d  = 2'd0;
        end
      end
      ST_LOAD: begin
        cv_start = 1'b1;
        state_d  = ST_CONV;
        if (update_req) pending_d = 1'b1;
      end
      ST_CONV: begin
        if (!cv_busy) state_d = ST_COMMIT;
        if (update_req) pending_d = 1'b1;
      end
      ST_COMMIT: begin
        commit_en = cv_valid;
        if (update_req) pending_d = 1'b1;
        if (cand_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LOAD;
          cand_d  = cand_q + 2'd1;
        end
      end
      ST_DONE: begin
        // a request landing in DONE is folded into the immediate re-run
        if (pending_q || update_req) begin
          state_d   = ST_LOAD;
          cand_d    = 2'd0;
          pending_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cand_q    <= 2'd0;
      pending_q <= 1'b0;
      for (int i = 0; i < 4; i++) disp_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      pending_q <= pending_d;
      if (commit_en) disp_q[cand_q] <= cv_bcd;
    end
  end

  assign busy = (state_q == ST_LOAD) || (state_q == ST_CONV) || (state_q == ST_COMMIT);
  assign done = (state_q == ST_DONE);

  logic             row;
  logic [3:0]       col;
  logic             in_field;
  logic [1:0]       fcand, fpos;
  logic [BCD_W-1:0] fword;
  logic [3:0]       fnib;
  logic [3:0]       fshift;

  always_comb begin
    row      = mem_addr[4];
    col      = mem_addr[3:0];
    in_field = 1'b0;
    fcand    = {row, 1'b0};
    fpos     = 2'd0;
    mem_bus  = ASCII_SPACE;
    if (col == COL_LETTER0) begin
      mem_bus = row ? ASCII_C : ASCII_A;
    end else if (col == COL_LETTER1) begin
      mem_bus = row ? ASCII_D : ASCII_B;
    end else if (col == COL_COLON0 || col == COL_COLON1) begin
      mem_bus = ASCII_COLON;
    end else if (col >= COL_FIELD0 && col < COL_FIELD0 + 4'd4) begin
      in_field = 1'b1;
      fpos     = 2'(col - COL_FIELD0);
    end else if (col >= COL_FIELD1 && col < COL_FIELD1 + 4'd4) begin
      in_field = 1'b1;
      fcand    = {row, 1'b1};
      fpos     = 2'(col - COL_FIELD1);
    end
    // fpos 0 is the thousands digit; shifting leaves it and all digits above
    fword  = disp_q[fcand];
    fshift = {2'd3 - fpos, 2'b00};
    fnib   = 4'(fword >> fshift);
    if (in_field) begin
      mem_bus = ASCII_ZERO + {4'b0000, fnib};
`ifdef LCD_LEAD_ZERO_BLANK_EN
      if (fpos != 2'd3 && (fword >> fshift) == '0) mem_bus = ASCII_SPACE;
`endif
    end
  end

endmodule

// File: tb/tb_lcd_vote_buffer.sv
// Directed self-checking bench for lcd_vote_buffer (CNT_W=10); expected
// screen text is built from decimal arithmetic, honouring LCD_LEAD_ZERO_BLANK_EN.
`timescale 1ns/100ps
module tb_lcd_vote_buffer;

  localparam int CNT_W = 10;
  localparam int LAT   = 4 * (CNT_W + 2) + 1;

  logic             clk;
  logic             rst_n;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic             update_req;
  logic             busy, done;
  logic [4:0]       mem_addr;
  logic [7:0]       mem_bus;

  int checks   = 0;
  int failures = 0;
  int exp_val [4];

  lcd_vote_buffer #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .cnt_c      (cnt_c),
    .cnt_d      (cnt_d),
    .update_req (update_req),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_bus    (mem_bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [7:0] digit_char(input int v, input int pos);
    int p10;
    p10 = 10 ** (3 - pos);
`ifdef LCD_LEAD_ZERO_BLANK_EN
    if (pos < 3 && v < p10) return 8'h20;
`endif
    return 8'h30 + 8'((v / p10) % 10);
  endfunction

  function automatic logic [7:0] exp_char(input int addr);
    int r, c;
    r = addr / 16;
    c = addr % 16;
    if (c == 0) return (r == 1) ? 8'h43 : 8'h41;
    if (c == 7) return (r == 1) ? 8'h44 : 8'h42;
    if (c == 1 || c == 8) return 8'h3A;
    if (c >= 2 && c <= 5) return digit_char(exp_val[2*r], c - 2);
    if (c >= 9 && c <= 12) return digit_char(exp_val[2*r+1], c - 9);
    return 8'h20;
  endfunction

  task automatic read_char(input int addr, output logic [7:0] ch);
    mem_addr = 5'(addr);
    #1;
    ch = mem_bus;
  endtask

  task automatic set_counts(input int a, input int b, input int c, input int d);
    cnt_a = CNT_W'(a);
    cnt_b = CNT_W'(b);
    cnt_c = CNT_W'(c);
    cnt_d = CNT_W'(d);
  endtask

  // leaves the bench at the negedge of cycle 1 (the LOAD cycle)
  task automatic pulse_req();
    @(negedge clk);
    update_req = 1'b1;
    @(negedge clk);
    update_req = 1'b0;
  endtask

  task automatic wait_done(input int start, output int n);
    n = start;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] ch;
    rst_n = 1'b0;
    update_req = 1'b0;
    mem_addr = '0;
    set_counts(0, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    for (int i = 0; i < 4; i++) exp_val[i] = 0;
    for (int a = 0; a < 32; a++) begin
      read_char(a, ch);
      checks++;
      if (ch !== exp_char(a)) begin
        failures++;
        $display("FAIL reset_screen addr=%0d got=%h expected=%h", a, ch, exp_char(a));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_conversion(input int a, input int b, input int c, input int d);
    logic [7:0] ch;
    int n;
    set_counts(a, b, c, d);
    pulse_req();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_rise got=%b expected=1", busy);
    end
    wait_done(1, n);
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL done_latency got=%0d expected=%0d", n, LAT);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_in_done got=%b expected=0", busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL after_done done=%b busy=%b expected 0 0", done, busy);
    end
    exp_val[0] = a; exp_val[1] = b; exp_val[2] = c; exp_val[3] = d;
    for (int i = 0; i < 32; i++) begin
      read_char(i, ch);
      checks++;
      if (ch !== exp_char(i)) begin
        failures++;
        $display("FAIL screen addr=%0d got=%h expected=%h", i, ch, exp_char(i));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_commit_atomic();
    logic [31:0] old_f, new_f, got, exp_f;
    logic [7:0]  ch;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) exp_val[i] = 0;
    for (int p = 0; p < 4; p++) old_f[8*(3-p) +: 8] = exp_char(18 + p);
    exp_val[2] = 57;
    for (int p = 0; p < 4; p++) new_f[8*(3-p) +: 8] = exp_char(18 + p);
    set_counts(1023, 0, 57, 400);
    pulse_req();
    for (int n = 1; n <= LAT; n++) begin
      if (n == LAT) begin
        checks++;
        if (done !== 1'b1) begin
          failures++;
          $display("FAIL atomic_done cycle=%0d got=%b expected=1", n, done);
        end
      end
      for (int p = 0; p < 4; p++) begin
        read_char(18 + p, ch);
        got[8*(3-p) +: 8] = ch;
      end
      exp_f = (n <= 36) ? old_f : new_f;
      checks++;
      if (got !== exp_f) begin
        failures++;
        $display("FAIL atomic_c cycle=%0d got=%h expected=%h", n, got, exp_f);
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] ch;
    int n, m;
    set_counts(1023, 0, 57, 400);
    pulse_req();
    repeat (9) @(negedge clk);
    update_req = 1'b1;
    cnt_b = CNT_W'(5);
    @(negedge clk);
    update_req = 1'b0;
    wait_done(11, n);
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL b2b_first_done got=%0d expected=%0d", n, LAT);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rerun busy=%b done=%b expected 1 0", busy, done);
    end
    wait_done(1, m);
    checks++;
    if (m != LAT) begin
      failures++;
      $display("FAIL b2b_second_done got=%0d expected=%0d", m, LAT);
    end
    exp_val[0] = 1023; exp_val[1] = 5; exp_val[2] = 57; exp_val[3] = 400;
    for (int i = 0; i < 32; i++) begin
      read_char(i, ch);
      checks++;
      if (ch !== exp_char(i)) begin
        failures++;
        $display("FAIL b2b_screen addr=%0d got=%h expected=%h", i, ch, exp_char(i));
      end
    end
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_third busy=%b expected=0", busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] ch;
    set_counts(200, 300, 400, 500);
    pulse_req();
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flags busy=%b done=%b expected 0 0", busy, done);
    end
    for (int i = 0; i < 4; i++) exp_val[i] = 0;
    for (int i = 0; i < 32; i++) begin
      read_char(i, ch);
      checks++;
      if (ch !== exp_char(i)) begin
        failures++;
        $display("FAIL midreset_screen addr=%0d got=%h expected=%h", i, ch, exp_char(i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_conversion(12, 345, 678, 1000);
  endtask

  initial begin
    test_reset();
    test_conversion(1023, 0, 57, 400);
    test_conversion(999, 100, 9, 10);
    test_commit_atomic();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
